// File: rtl/prot_trig_seq.sv
// rtl/prot_trig_seq.sv - SPI/UART protocol trigger with masked match and occurrence count
module prot_trig_seq #(
    parameter int SPI_W  = 16,
    parameter int UART_W = 8,
    parameter int BAUD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CH1L,
    input  logic              CH2L,
    input  logic              CH3L,
    input  logic [3:0]        TrigCfg,
    input  logic              armed,
    input  logic [SPI_W-1:0]  mask,
    input  logic [SPI_W-1:0]  match,
    input  logic [BAUD_W-1:0] baud_cnt,
    input  logic [CNT_W-1:0]  occ_cnt,
    output logic              protTrig,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int BIT_W = 4;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

    logic [1:0]        ch1_sync_q;
    logic [2:0]        ch2_sync_q;
    logic [1:0]        ch3_sync_q;
    logic              ss_prev_q;
    logic [SPI_W-1:0]  shreg_q, shreg_d;
    uart_state_t       uart_state_q, uart_state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bitn_q, bitn_d;
    logic [UART_W-1:0] data_q, data_d;
    logic              uart_done_q, uart_done_d;
    logic              uart_m_q, uart_m_d;
    logic              spi_hit_q, spi_hit_d;
    logic              uart_hit_q, uart_hit_d;
    logic              cond_q, cond_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic              prot_trig_q, prot_trig_d;

    logic              ss, sclk, sclk_prev, mosi, rx;
    logic              ss_fall, ss_rise, spi_shift, spi_m;
    logic [SPI_W-1:0]  spi_diff;
    logic [UART_W-1:0] uart_diff;
    logic              baud_tc;
    logic              cond, both_dis, event_hit;
    logic [CNT_W-1:0]  occ_eff, evt_inc;

    // Input synchronizers; idle-high reset so leaving reset does not look like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch1_sync_q <= '1;
            ch2_sync_q <= '1;
            ch3_sync_q <= '1;
            ss_prev_q  <= 1'b1;
        end else begin
            ch1_sync_q <= {ch1_sync_q[0], CH1L};
            ch2_sync_q <= {ch2_sync_q[1:0], CH2L};
            ch3_sync_q <= {ch3_sync_q[0], CH3L};
            ss_prev_q  <= ch1_sync_q[1];
        end
    end

    assign ss        = ch1_sync_q[1];
    assign rx        = ch1_sync_q[1];
    assign sclk      = ch2_sync_q[1];
    assign sclk_prev = ch2_sync_q[2];
    assign mosi      = ch3_sync_q[1];
    assign ss_fall   = ss_prev_q & ~ss;
    assign ss_rise   = ~ss_prev_q & ss;
    assign spi_shift = ~ss & (TrigCfg[3] ? (sclk & ~sclk_prev) : (~sclk & sclk_prev));
    assign spi_diff  = (shreg_q ^ match) & ~mask;
    assign spi_m     = TrigCfg[2] ? (spi_diff[7:0] == 8'h00) : (spi_diff == '0);

    // SPI shift register: cleared on select, MSB-first shift, overflow drops off the top
    always_comb begin
        shreg_d = shreg_q;
        if (ss_fall) begin
            shreg_d = '0;
        end else if (spi_shift) begin
            shreg_d = {shreg_q[SPI_W-2:0], mosi};
        end
    end

    // SPI shift register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg_q <= '0;
        else        shreg_q <= shreg_d;
    end

    assign baud_tc   = (baud_q <= BAUD_W'(1));
    assign uart_diff = (data_q ^ match[UART_W-1:0]) & ~mask[UART_W-1:0];

    // UART receiver: half-bit wait to mid-start, then one sample per bit period
    always_comb begin
        uart_state_d = uart_state_q;
        baud_d       = baud_q;
        bitn_d       = bitn_q;
        data_d       = data_q;
        uart_done_d  = 1'b0;
        uart_m_d     = 1'b0;
        case (uart_state_q)
            U_IDLE: begin
                if (!rx) begin
                    uart_state_d = U_START;
                    baud_d       = baud_cnt >> 1;
                end
            end
            U_START: begin
                if (baud_tc) begin
                    baud_d = baud_cnt;
                    bitn_d = '0;
                    uart_state_d = rx ? U_IDLE : U_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            U_DATA: begin
                if (baud_tc) begin
                    baud_d = baud_cnt;
                    data_d = {rx, data_q[UART_W-1:1]};
                    if (bitn_q == BIT_W'(UART_W - 1)) uart_state_d = U_STOP;
                    else                              bitn_d = bitn_q + BIT_W'(1);
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            U_STOP: begin
                if (baud_tc) begin
                    baud_d       = baud_cnt;
                    uart_done_d  = 1'b1;
                    uart_m_d     = rx & (uart_diff == '0);
                    uart_state_d = U_IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: uart_state_d = U_IDLE;
        endcase
    end

    // UART receiver state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_state_q <= U_IDLE;
            baud_q       <= '0;
            bitn_q       <= '0;
            data_q       <= '0;
            uart_done_q  <= 1'b0;
            uart_m_q     <= 1'b0;
        end else begin
            uart_state_q <= uart_state_d;
            baud_q       <= baud_d;
            bitn_q       <= bitn_d;
            data_q       <= data_d;
            uart_done_q  <= uart_done_d;
            uart_m_q     <= uart_m_d;
        end
    end

    assign cond      = (spi_hit_q | TrigCfg[1]) & (uart_hit_q | TrigCfg[0]);
    assign both_dis  = &TrigCfg[1:0];
    assign event_hit = cond & ~cond_q;
    assign occ_eff   = (occ_cnt == '0) ? CNT_W'(1) : occ_cnt;
    assign evt_inc   = (evt_cnt_q == '1) ? evt_cnt_q : evt_cnt_q + CNT_W'(1);

    // Hit flags, rising-edge event counting and the sticky trigger
    always_comb begin
        spi_hit_d   = ss_rise ? spi_m : spi_hit_q;
        uart_hit_d  = uart_done_q ? uart_m_q : uart_hit_q;
        cond_d      = cond;
        evt_cnt_d   = evt_cnt_q;
        prot_trig_d = prot_trig_q;
        if (!armed) begin
            spi_hit_d   = 1'b0;
            uart_hit_d  = 1'b0;
            cond_d      = 1'b0;
            evt_cnt_d   = '0;
            prot_trig_d = 1'b0;
        end else if (both_dis) begin
            evt_cnt_d   = '0;
            prot_trig_d = 1'b1;
        end else if (event_hit) begin
            evt_cnt_d = evt_inc;
            if (evt_inc >= occ_eff) prot_trig_d = 1'b1;
        end
    end

    // Trigger state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_hit_q   <= 1'b0;
            uart_hit_q  <= 1'b0;
            cond_q      <= 1'b0;
            evt_cnt_q   <= '0;
            prot_trig_q <= 1'b0;
        end else begin
            spi_hit_q   <= spi_hit_d;
            uart_hit_q  <= uart_hit_d;
            cond_q      <= cond_d;
            evt_cnt_q   <= evt_cnt_d;
            prot_trig_q <= prot_trig_d;
        end
    end

    assign protTrig = prot_trig_q;
    assign evt_cnt  = evt_cnt_q;

endmodule
